// File: rtl/bin_to_gray_wptr.sv
// -----------------------------------------------------------------------------
// bin_to_gray_wptr
//   Write-side pointer logic for an asynchronous FIFO. Keeps a binary write
//   pointer (used to address the memory) and a registered Gray copy of it
//   (sent across to the read domain). It also produces a registered full flag.
//   The flag compares the next Gray write pointer against the read pointer,
//   which has already been synchronized into this clock domain.
//
// Parameters
//   a_length        FIFO address width; depth = 2**a_length, pointers are
//                   a_length+1 bits wide (extra bit distinguishes full/empty)
//
// Ports
//   clk             write-domain clock, all state updates on rising edge
//   rst             synchronous active-high reset
//   inc             write request from the producer
//   rptr_gray_sync  Gray read pointer, already synchronized into clk domain
//   wr_en           write accepted this cycle (inc and not full), to memory
//   waddr           memory write address, straight from the binary pointer
//   wptr_gray       registered Gray write pointer, to the read domain
//   full            registered FIFO-full flag
// -----------------------------------------------------------------------------
module bin_to_gray_wptr #(
    parameter int a_length = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic [a_length:0]   rptr_gray_sync,
    output logic                wr_en,
    output logic [a_length-1:0] waddr,
    output logic [a_length:0]   wptr_gray,
    output logic                full
);

    localparam int P = a_length + 1;

    // Full means the write pointer is exactly one lap ahead of the read
    // pointer. In Gray code that is the read pointer with its two MSBs
    // inverted and its remaining bits equal. XOR with this mask does the
    // inversion.
    localparam logic [P-1:0] FULL_MASK = ~({P{1'b1}} >> 2);

    logic [P-1:0] bin_q, bin_d;
    logic [P-1:0] gray_q, gray_d;
    logic         full_q, full_d;

    always_comb begin
        wr_en  = inc & ~full_q;
        // Natural modulo-2^P wrap, no saturation.
        bin_d  = bin_q + {{(P-1){1'b0}}, wr_en};
        gray_d = bin_d ^ (bin_d >> 1);
        // Evaluated every cycle, so a read-pointer advance clears full even
        // when no write is requested.
        full_d = (gray_d == (rptr_gray_sync ^ FULL_MASK));
    end

    // ---- register stage: pointers and full flag ----
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            full_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            full_q <= full_d;
        end
    end

    assign waddr     = bin_q[a_length-1:0];
    assign wptr_gray = gray_q;
    assign full      = full_q;

endmodule

// File: tb/tb_bin_to_gray_wptr.sv
module tb_bin_to_gray_wptr;

    logic       clk;
    logic       rst;
    logic       inc;
    logic [3:0] rptr_gray_sync;
    logic       wr_en;
    logic [2:0] waddr;
    logic [3:0] wptr_gray;
    logic       full;

    int checks;
    int failures;

    // Hand-written 4-bit Gray sequence, index = binary value.
    logic [3:0] G [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                          4'b0110, 4'b0111, 4'b0101, 4'b0100,
                          4'b1100, 4'b1101, 4'b1111, 4'b1110,
                          4'b1010, 4'b1011, 4'b1001, 4'b1000};

    bin_to_gray_wptr #(.a_length(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .inc            (inc),
        .rptr_gray_sync (rptr_gray_sync),
        .wr_en          (wr_en),
        .waddr          (waddr),
        .wptr_gray      (wptr_gray),
        .full           (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        inc = 1'b0;
        rptr_gray_sync = 4'b0000;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        inc = 1'b1;
        rptr_gray_sync = 4'b0000;
        step();
        checks++; if (wptr_gray !== 4'b0000) begin failures++; $display("FAIL reset_wptr got=%b exp=0000", wptr_gray); end
        checks++; if (waddr !== 3'd0) begin failures++; $display("FAIL reset_waddr got=%0d exp=0", waddr); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL reset_wren_inc1 got=%b exp=1", wr_en); end
        inc = 1'b0;
        #1;
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wren_inc0 got=%b exp=0", wr_en); end
        // Reset held with inc high: no pointer advance.
        inc = 1'b1;
        step();
        checks++; if (wptr_gray !== 4'b0000) begin failures++; $display("FAIL reset_hold_wptr got=%b exp=0000", wptr_gray); end
        rst = 1'b0;
        inc = 1'b0;
    endtask

    task automatic test_fill();
        logic [3:0] exp_g [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                  4'b0111, 4'b0101, 4'b0100, 4'b1100};
        do_reset();
        rptr_gray_sync = 4'b0000;
        inc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL fill_wren[%0d] got=%b exp=1", i, wr_en); end
            step();
            checks++; if (wptr_gray !== exp_g[i]) begin failures++; $display("FAIL fill_wptr[%0d] got=%b exp=%b", i, wptr_gray, exp_g[i]); end
            checks++; if (waddr !== 3'((i + 1) % 8)) begin failures++; $display("FAIL fill_waddr[%0d] got=%0d exp=%0d", i, waddr, (i + 1) % 8); end
            checks++; if (full !== (i == 7)) begin failures++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i == 7)); end
        end
        // Ninth request is refused.
        #1;
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL fill_wren_full got=%b exp=0", wr_en); end
        step();
        checks++; if (wptr_gray !== 4'b1100) begin failures++; $display("FAIL fill_hold_wptr got=%b exp=1100", wptr_gray); end
        checks++; if (waddr !== 3'd0) begin failures++; $display("FAIL fill_hold_waddr got=%0d exp=0", waddr); end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_hold_full got=%b exp=1", full); end
        inc = 1'b0;
    endtask

    // Continues from the full state left by test_fill.
    task automatic test_release();
        rptr_gray_sync = 4'b0001;
        inc = 1'b0;
        step();
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL release_full got=%b exp=0", full); end
        checks++; if (wptr_gray !== 4'b1100) begin failures++; $display("FAIL release_wptr got=%b exp=1100", wptr_gray); end
        inc = 1'b1;
        #1;
        checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL release_wren got=%b exp=1", wr_en); end
        checks++; if (waddr !== 3'd0) begin failures++; $display("FAIL release_waddr got=%0d exp=0", waddr); end
        step();
        // bin=9 vs read pointer 1: full again.
        checks++; if (wptr_gray !== 4'b1101) begin failures++; $display("FAIL release_wptr2 got=%b exp=1101", wptr_gray); end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL release_refull got=%b exp=1", full); end
        inc = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            rptr_gray_sync = G[(k + 12) % 16];  // read pointer four behind
            inc = 1'b1;
            #1;
            checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL wrap_wren[%0d] got=%b exp=1", k, wr_en); end
            step();
            checks++; if (wptr_gray !== G[(k + 1) % 16]) begin failures++; $display("FAIL wrap_wptr[%0d] got=%b exp=%b", k, wptr_gray, G[(k + 1) % 16]); end
            checks++; if (waddr !== 3'((k + 1) % 8)) begin failures++; $display("FAIL wrap_waddr[%0d] got=%0d exp=%0d", k, waddr, (k + 1) % 8); end
            checks++; if (full !== 1'b0) begin failures++; $display("FAIL wrap_full[%0d] got=%b exp=0", k, full); end
        end
        inc = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        inc = 1'b1;
        for (int i = 0; i < 4; i++) step();
        checks++; if (wptr_gray !== 4'b0110) begin failures++; $display("FAIL mid_pre_wptr got=%b exp=0110", wptr_gray); end
        rst = 1'b1;
        #1;
        checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL mid_wren got=%b exp=1", wr_en); end
        step();
        checks++; if (wptr_gray !== 4'b0000) begin failures++; $display("FAIL mid_wptr got=%b exp=0000", wptr_gray); end
        checks++; if (waddr !== 3'd0) begin failures++; $display("FAIL mid_waddr got=%0d exp=0", waddr); end
        rst = 1'b0;
        // Fill, then reset while full.
        for (int i = 0; i < 8; i++) step();
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL mid_prefull got=%b exp=1", full); end
        rst = 1'b1;
        step();
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL mid_full_cleared got=%b exp=0", full); end
        checks++; if (wptr_gray !== 4'b0000) begin failures++; $display("FAIL mid_full_wptr got=%b exp=0000", wptr_gray); end
        rst = 1'b0;
        inc = 1'b0;
    endtask

    task automatic test_random_gray();
        int wb, rb, accepted, cycles, occ;
        logic exp_full, exp_wr;
        logic [3:0] prev_g;
        do_reset();
        wb = 0; rb = 0; accepted = 0; cycles = 0;
        exp_full = 1'b0;
        prev_g = 4'b0000;
        while (accepted < 64 && cycles < 2000) begin
            cycles++;
            occ = (wb - rb) & 15;
            if (occ > 0 && $urandom_range(0, 2) == 0) rb = (rb + 1) & 15;
            rptr_gray_sync = G[rb];
            inc = ($urandom_range(0, 3) != 0);
            exp_wr = inc && !exp_full;
            #1;
            checks++; if (wr_en !== exp_wr) begin failures++; $display("FAIL rand_wren[%0d] got=%b exp=%b", cycles, wr_en, exp_wr); end
            if (exp_wr) begin
                wb = (wb + 1) & 15;
                accepted++;
            end
            exp_full = (((wb - rb) & 15) == 8);
            step();
            checks++; if (full !== exp_full) begin failures++; $display("FAIL rand_full[%0d] got=%b exp=%b", cycles, full, exp_full); end
            checks++; if (wptr_gray !== G[wb]) begin failures++; $display("FAIL rand_wptr[%0d] got=%b exp=%b", cycles, wptr_gray, G[wb]); end
            checks++; if ($countones(wptr_gray ^ prev_g) !== (exp_wr ? 1 : 0)) begin failures++; $display("FAIL rand_hamming[%0d] got=%0d exp=%0d", cycles, $countones(wptr_gray ^ prev_g), (exp_wr ? 1 : 0)); end
            prev_g = wptr_gray;
        end
        checks++; if (accepted < 64) begin failures++; $display("FAIL rand_budget got=%0d exp=64 accepted writes", accepted); end
        inc = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        inc = 1'b0;
        rptr_gray_sync = 4'b0000;
        test_reset();
        test_fill();
        test_release();
        test_wrap();
        test_reset_mid();
        test_random_gray();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
